bram_read_arbiter: RTL and testbench
====================================

Name: bram_read_arbiter

Overview:
- Shares the single BRAM read port between N_REQ requesters (slot 0 = AES controller, slot 1 = SHA controller, further slots spare).
- Round-robin arbitration; one outstanding BRAM read at a time; level start_read / pulse complete handshake on both sides.
- Watchdog aborts a read the BRAM never completes, returning an error completion so no requester hangs.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 1024, WAIT cycles before abort; 0 disables the watchdog.
- ERR_DATA, 32'h0, value driven on rd_data for an aborted read.

Ports:
- arb_clk  input  1  clock.
- arb_rst_n  input  1  reset; asynchronous assert, active-low.
- req_start_read  input  N_REQ  per-requester read request, level; held until its req_complete.
- req_addr  input  32*N_REQ  byte address; slot i at bits [32*i+31:32*i].
- req_complete  output  N_REQ  one-cycle completion pulse to the granted requester.
- req_error  output  1  high with req_complete when the read was aborted by timeout.
- rd_data  output  32  read data; valid while req_complete is high, held until the next completion.
- grant_id  output  3  index of the current or last granted requester.
- arb_busy  output  1  high in any state other than IDLE.
- bram_start_read  output  1  read request to the BRAM controller, level.
- bram_addr  output  32  read address to the BRAM controller.
- bram_complete  input  1  BRAM read done; bram_read_data valid in the same cycle.
- bram_read_data  input  32  BRAM read data.

Behaviour:
- Reset values: every output 0; state IDLE; round-robin pointer = N_REQ-1, so slot 0 wins first; watchdog counter 0. Reset asserted mid-read drops bram_start_read immediately and issues no completion.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If any req_start_read bit is set, grant the first set bit searching upward from pointer+1 with wrap.
  - Register grant_id, bram_addr = that slot's address, bram_start_read = 1, pointer = granted index, counter = 0. Next state WAIT.
  - Latency: request seen at edge T gives bram_start_read high after edge T, so the BRAM sees it at edge T+1.
- WAIT:
  - bram_start_read and bram_addr stay stable.
  - On bram_complete = 1: rd_data = bram_read_data, bram_start_read = 0, req_complete[grant_id] = 1, req_error = 0. Next state RESP.
  - Otherwise, if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1: rd_data = ERR_DATA, bram_start_read = 0, req_complete[grant_id] = 1, req_error = 1. Next state RESP.
  - Otherwise counter + 1 (32-bit, saturates).
  - bram_complete and timeout in the same cycle: complete wins, req_error = 0.
- RESP:
  - Exactly one cycle: clear req_complete and req_error, then go to IDLE.
  - Requests are not sampled in RESP. This gives the granted requester one cycle to drop req_start_read, so a stale level is never re-granted.
- Fairness: the granted slot becomes lowest priority. With all N_REQ requesting continuously, grants rotate 0,1,...,N_REQ-1,0,...
- Back-to-back throughput: at most one grant per 3 cycles plus BRAM latency.
- bram_complete outside WAIT (e.g. a late reply after a timeout) is ignored: no data capture, no completion.
- A requester dropping req_start_read while granted does not cancel the read; its completion is still pulsed.
- req_start_read bits above N_REQ-1 do not exist; grant_id upper bits are 0 when N_REQ < 8.
- rd_data is not cleared by RESP or IDLE.

Test Plan:
- Single read: slot 0 requests addr 32'h100, BRAM completes 3 cycles after bram_start_read with 32'hCAFEF00D -> bram_addr = 32'h100; req_complete = 2'b01 for exactly 1 cycle; rd_data = 32'hCAFEF00D; req_error = 0; arb_busy low 1 cycle after RESP.
- Contention: both slots request from reset (addr 32'h0 and 32'h40), each re-requesting after its completion, over 6 reads -> grant order 0,1,0,1,0,1; bram_addr alternates 32'h0/32'h40; no slot granted twice in a row.
- AES-style 12-word burst: slot 0 issues sequential reads 32'h200..32'h22C while slot 1 is idle -> 12 completions with data matching the BRAM model in order; a stale request is never re-granted in RESP.
- Timeout with TIMEOUT_CYCLES = 8: BRAM never completes -> bram_start_read high for exactly 8 cycles, then req_complete with req_error = 1 and rd_data = ERR_DATA. A bram_complete injected 2 cycles later is ignored.
- Complete/timeout race: bram_complete asserted in the 8th WAIT cycle (TIMEOUT_CYCLES = 8) -> req_error = 0, rd_data = BRAM data.
- Reset mid-WAIT: arb_rst_n low during WAIT -> all outputs 0 asynchronously; after release, a new slot 1 request is granted as slot 1 (pointer reset) with no spurious completion.

Source files
------------

// File: rtl/bram_read_arbiter.sv
// Round-robin arbiter sharing one BRAM read port between N_REQ requesters.
// One read outstanding at a time; a watchdog turns a read the BRAM never
// completes into an error completion so no requester can hang.
module bram_read_arbiter #(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = 32'h0
) (
  input  logic                  arb_clk,
  input  logic                  arb_rst_n,
  input  logic [N_REQ-1:0]      req_start_read,
  input  logic [32*N_REQ-1:0]   req_addr,
  output logic [N_REQ-1:0]      req_complete,
  output logic                  req_error,
  output logic [31:0]           rd_data,
  output logic [2:0]            grant_id,
  output logic                  arb_busy,
  output logic                  bram_start_read,
  output logic [31:0]           bram_addr,
  input  logic                  bram_complete,
  input  logic [31:0]           bram_read_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [2:0]         grant_q, grant_d;
  logic [31:0]        addr_q, addr_d;
  logic               start_q, start_d;
  logic [N_REQ-1:0]   comp_q, comp_d;
  logic               err_q, err_d;
  logic [31:0]        data_q, data_d;

  logic               arb_found;
  logic [2:0]         arb_idx;
  logic [31:0]        arb_addr;
  logic [31:0]        cand;
  logic               timeout_hit;

  // Round-robin search: first requesting slot starting just above the pointer, with wrap
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = (32'(ptr_q) + k) % N_REQ;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!arb_found && (cand == i) && req_start_read[i]) begin
          arb_found = 1'b1;
          arb_idx   = 3'(i);
        end
      end
    end
  end

  // Address of the winning slot
  always_comb begin
    arb_addr = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (arb_idx == 3'(i)) begin
        arb_addr = req_addr[32*i +: 32];
      end
    end
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES - 1);

  // Next-state logic for the IDLE/WAIT/RESP handshake FSM and its registered outputs
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    start_d = start_q;
    comp_d  = comp_q;
    err_d   = err_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          grant_d = arb_idx;
          addr_d  = arb_addr;
          start_d = 1'b1;
          ptr_d   = arb_idx;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A genuine completion takes precedence over a watchdog expiry in the same cycle
        if (bram_complete || timeout_hit) begin
          data_d  = bram_complete ? bram_read_data : ERR_DATA;
          err_d   = !bram_complete;
          start_d = 1'b0;
          for (int unsigned i = 0; i < N_REQ; i++) begin
            comp_d[i] = (grant_q == 3'(i));
          end
          state_d = S_RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_RESP: begin
        // Requests are deliberately not sampled here so the granted slot can drop its level
        comp_d  = '0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any read without a completion
  always_ff @(posedge arb_clk or negedge arb_rst_n) begin
    if (!arb_rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 3'(N_REQ - 1);
      cnt_q   <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      start_q <= 1'b0;
      comp_q  <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      start_q <= start_d;
      comp_q  <= comp_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign req_complete    = comp_q;
  assign req_error       = err_q;
  assign rd_data         = data_q;
  assign grant_id        = grant_q;
  assign arb_busy        = (state_q != S_IDLE);
  assign bram_start_read = start_q;
  assign bram_addr       = addr_q;

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Self-checking bench for bram_read_arbiter (2 requesters, 8-cycle watchdog).
module tb_bram_read_arbiter;

  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        arb_clk = 1'b0;
  logic        arb_rst_n;
  logic [1:0]  req_start_read;
  logic [63:0] req_addr;
  logic [1:0]  req_complete;
  logic        req_error;
  logic [31:0] rd_data;
  logic [2:0]  grant_id;
  logic        arb_busy;
  logic        bram_start_read;
  logic [31:0] bram_addr;
  logic        bram_complete;
  logic [31:0] bram_read_data;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  comp;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];

  bram_read_arbiter #(
    .N_REQ(2),
    .TIMEOUT_CYCLES(8),
    .ERR_DATA(ERR)
  ) dut (
    .arb_clk(arb_clk),
    .arb_rst_n(arb_rst_n),
    .req_start_read(req_start_read),
    .req_addr(req_addr),
    .req_complete(req_complete),
    .req_error(req_error),
    .rd_data(rd_data),
    .grant_id(grant_id),
    .arb_busy(arb_busy),
    .bram_start_read(bram_start_read),
    .bram_addr(bram_addr),
    .bram_complete(bram_complete),
    .bram_read_data(bram_read_data)
  );

  always #5 arb_clk = ~arb_clk;

  function automatic logic [31:0] bram_mem(input logic [31:0] a);
    if (a == 32'h100) return 32'hCAFEF00D;
    return (a * 32'd2654435761) ^ 32'h5A5A0F0F;
  endfunction

  task automatic set_req(input int s, input logic v, input logic [31:0] a);
    if (s == 0) begin
      req_start_read[0] = v;
      req_addr[31:0]    = a;
    end else begin
      req_start_read[1] = v;
      req_addr[63:32]   = a;
    end
  endtask

  // Plays the BRAM (completes after lat cycles of start_read, 0 = never) until a completion
  task automatic wait_done(input int lat, input int budget, output logic ok,
                           output logic [1:0] comp, output logic [31:0] data,
                           output logic err, output logic [2:0] gid,
                           output int hi, output logic [31:0] addr_seen);
    ok = 1'b0; comp = '0; data = '0; err = 1'b0; gid = '0; hi = 0; addr_seen = '0;
    for (int c = 0; c < budget; c++) begin
      @(negedge arb_clk);
      if (req_complete != 2'b00) begin
        comp = req_complete; data = rd_data; err = req_error; gid = grant_id;
        ok = 1'b1;
        break;
      end
      bram_complete = 1'b0;
      if (bram_start_read) begin
        hi++;
        if (hi == 1) addr_seen = bram_addr;
        if (lat != 0 && hi == lat) begin
          bram_complete  = 1'b1;
          bram_read_data = bram_mem(bram_addr);
        end
      end
    end
    bram_complete = 1'b0;
  endtask

  task automatic test_reset();
    arb_rst_n = 1'b0; req_start_read = '0; req_addr = '0;
    bram_complete = 1'b0; bram_read_data = '0;
    repeat (3) @(negedge arb_clk);
    checks++;
    if ({req_complete, req_error, grant_id, arb_busy, bram_start_read} !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctrl got=%h want=00",
               {req_complete, req_error, grant_id, arb_busy, bram_start_read});
    end
    checks++;
    if (rd_data !== 32'h0) begin failures++; $display("FAIL reset_rd_data got=%h want=0", rd_data); end
    checks++;
    if (bram_addr !== 32'h0) begin failures++; $display("FAIL reset_bram_addr got=%h want=0", bram_addr); end
    arb_rst_n = 1'b1;
    @(negedge arb_clk);
    checks++;
    if (arb_busy !== 1'b0) begin failures++; $display("FAIL reset_idle busy=%b want=0", arb_busy); end
  endtask

  task automatic test_single_read();
    logic ok, err; logic [1:0] comp; logic [31:0] data, aseen; logic [2:0] gid; int hi;
    exp_t e;
    set_req(0, 1'b1, 32'h100);
    sb.push_back('{2'b01, 32'hCAFEF00D, 1'b0});
    wait_done(3, 50, ok, comp, data, err, gid, hi, aseen);
    e = sb.pop_front();
    checks++;
    if (!ok || {comp, data, err} !== {e.comp, e.data, e.err}) begin
      failures++;
      $display("FAIL single_resp ok=%b got=%b/%h/%b want=%b/%h/%b", ok, comp, data, err, e.comp, e.data, e.err);
    end
    checks++;
    if (aseen !== 32'h100) begin failures++; $display("FAIL single_addr got=%h want=100", aseen); end
    set_req(0, 1'b0, 32'h100);
    @(negedge arb_clk);
    checks++;
    if ({req_complete, arb_busy} !== 3'b000) begin
      failures++; $display("FAIL single_pulse comp=%b busy=%b want=00/0", req_complete, arb_busy);
    end
    checks++;
    if (rd_data !== 32'hCAFEF00D) begin failures++; $display("FAIL single_hold got=%h want=cafef00d", rd_data); end
  endtask

  task automatic test_contention();
    logic ok, err; logic [1:0] comp; logic [31:0] data, aseen, a; logic [2:0] gid; int hi;
    int prev, s;
    exp_t e;
    arb_rst_n = 1'b0;
    @(negedge arb_clk);
    arb_rst_n = 1'b1;
    set_req(0, 1'b1, 32'h0);
    set_req(1, 1'b1, 32'h40);
    prev = -1;
    for (int r = 0; r < 6; r++) begin
      s = r % 2;
      a = (s == 0) ? 32'h0 : 32'h40;
      sb.push_back('{(s == 0) ? 2'b01 : 2'b10, bram_mem(a), 1'b0});
      wait_done(2, 50, ok, comp, data, err, gid, hi, aseen);
      e = sb.pop_front();
      checks++;
      if (!ok || {comp, data, err} !== {e.comp, e.data, e.err}) begin
        failures++;
        $display("FAIL contention_resp r=%0d ok=%b got=%b/%h/%b want=%b/%h/%b", r, ok, comp, data, err, e.comp, e.data, e.err);
      end
      checks++;
      if (int'(gid) != s || int'(gid) == prev) begin
        failures++; $display("FAIL contention_grant r=%0d got=%0d want=%0d prev=%0d", r, gid, s, prev);
      end
      checks++;
      if (aseen !== a) begin failures++; $display("FAIL contention_addr r=%0d got=%h want=%h", r, aseen, a); end
      prev = int'(gid);
      set_req(s, 1'b0, a);
      @(negedge arb_clk);
      set_req(s, 1'b1, a);
    end
    set_req(0, 1'b0, 32'h0);
    set_req(1, 1'b0, 32'h40);
    repeat (4) @(negedge arb_clk);
  endtask

  task automatic test_burst();
    logic ok, err; logic [1:0] comp; logic [31:0] data, aseen, a; logic [2:0] gid; int hi;
    exp_t e;
    for (int k = 0; k < 12; k++) begin
      a = 32'h200 + 32'(4 * k);
      set_req(0, 1'b1, a);
      sb.push_back('{2'b01, bram_mem(a), 1'b0});
      wait_done(int'($urandom_range(1, 4)), 50, ok, comp, data, err, gid, hi, aseen);
      e = sb.pop_front();
      checks++;
      if (!ok || {comp, data, err} !== {e.comp, e.data, e.err} || aseen !== a) begin
        failures++;
        $display("FAIL burst_resp k=%0d ok=%b got=%b/%h/%b@%h want=%b/%h/%b@%h", k, ok, comp, data, err, aseen, e.comp, e.data, e.err, a);
      end
      set_req(0, 1'b0, a);
      @(negedge arb_clk);
      checks++;
      if ({bram_start_read, req_complete} !== 3'b000) begin
        failures++; $display("FAIL burst_stale k=%0d start=%b comp=%b want=0/00", k, bram_start_read, req_complete);
      end
    end
  endtask

  task automatic test_timeout();
    logic ok, err; logic [1:0] comp; logic [31:0] data, aseen; logic [2:0] gid; int hi;
    exp_t e;
    set_req(1, 1'b1, 32'h300);
    sb.push_back('{2'b10, ERR, 1'b1});
    wait_done(0, 50, ok, comp, data, err, gid, hi, aseen);
    e = sb.pop_front();
    checks++;
    if (!ok || {comp, data, err} !== {e.comp, e.data, e.err}) begin
      failures++;
      $display("FAIL timeout_resp ok=%b got=%b/%h/%b want=%b/%h/%b", ok, comp, data, err, e.comp, e.data, e.err);
    end
    checks++;
    if (hi != 8) begin failures++; $display("FAIL timeout_len got=%0d want=8", hi); end
    set_req(1, 1'b0, 32'h300);
    @(negedge arb_clk);
    @(negedge arb_clk);
    bram_complete  = 1'b1;
    bram_read_data = 32'h12345678;
    @(negedge arb_clk);
    bram_complete = 1'b0;
    checks++;
    if (req_complete !== 2'b00) begin failures++; $display("FAIL late_complete comp=%b want=00", req_complete); end
    @(negedge arb_clk);
    checks++;
    if ({req_complete, arb_busy} !== 3'b000 || rd_data !== ERR) begin
      failures++; $display("FAIL late_ignored comp=%b busy=%b data=%h want=00/0/%h", req_complete, arb_busy, rd_data, ERR);
    end
  endtask

  task automatic test_race();
    logic ok, err; logic [1:0] comp; logic [31:0] data, aseen; logic [2:0] gid; int hi;
    exp_t e;
    set_req(0, 1'b1, 32'h44);
    sb.push_back('{2'b01, bram_mem(32'h44), 1'b0});
    wait_done(8, 50, ok, comp, data, err, gid, hi, aseen);
    e = sb.pop_front();
    checks++;
    if (!ok || {comp, data, err} !== {e.comp, e.data, e.err} || hi != 8) begin
      failures++;
      $display("FAIL race_resp ok=%b hi=%0d got=%b/%h/%b want=%b/%h/%b", ok, hi, comp, data, err, e.comp, e.data, e.err);
    end
    set_req(0, 1'b0, 32'h44);
    repeat (2) @(negedge arb_clk);
  endtask

  task automatic test_reset_mid_wait();
    logic ok, err; logic [1:0] comp; logic [31:0] data, aseen; logic [2:0] gid; int hi;
    exp_t e;
    set_req(0, 1'b1, 32'h80);
    wait_done(0, 4, ok, comp, data, err, gid, hi, aseen);
    checks++;
    if (ok || bram_start_read !== 1'b1) begin
      failures++; $display("FAIL midwait_setup ok=%b start=%b want=0/1", ok, bram_start_read);
    end
    #2;
    arb_rst_n = 1'b0;
    #1;
    checks++;
    if ({req_complete, req_error, grant_id, arb_busy, bram_start_read} !== 8'h00 ||
        rd_data !== 32'h0 || bram_addr !== 32'h0) begin
      failures++;
      $display("FAIL async_reset ctrl=%h data=%h addr=%h want=00/0/0",
               {req_complete, req_error, grant_id, arb_busy, bram_start_read}, rd_data, bram_addr);
    end
    set_req(0, 1'b0, 32'h80);
    @(negedge arb_clk);
    arb_rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge arb_clk);
      checks++;
      if ({req_complete, bram_start_read} !== 3'b000) begin
        failures++; $display("FAIL post_reset_spurious c=%0d comp=%b start=%b want=00/0", c, req_complete, bram_start_read);
      end
    end
    set_req(1, 1'b1, 32'h140);
    sb.push_back('{2'b10, bram_mem(32'h140), 1'b0});
    wait_done(2, 50, ok, comp, data, err, gid, hi, aseen);
    e = sb.pop_front();
    checks++;
    if (!ok || {comp, data, err} !== {e.comp, e.data, e.err} || gid !== 3'd1) begin
      failures++;
      $display("FAIL post_reset_read ok=%b gid=%0d got=%b/%h/%b want=1 %b/%h/%b", ok, gid, comp, data, err, e.comp, e.data, e.err);
    end
    set_req(1, 1'b0, 32'h140);
    repeat (2) @(negedge arb_clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_burst();
    test_timeout();
    test_race();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
